// File: rtl/mips_bus_pkg.sv
// Shared types and lane helpers for the MIPS Avalon-MM master port.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_RESP = 2'b10
  } bus_state_t;

  localparam int unsigned MAX_DATA_W = 64;
  localparam int unsigned MAX_BE_W   = 8;

  // Reserved size or an address not aligned to the access size.
  function automatic logic size_err(input logic [1:0] size, input logic [1:0] addr_lo);
    logic err;
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = addr_lo[0];
      SZ_WORD: err = (addr_lo != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  // Byte-lane enables for an access of the given size starting at lane.
  function automatic logic [MAX_BE_W-1:0] be_mask(input logic [1:0] size, input logic [2:0] lane);
    logic [MAX_BE_W-1:0] be;
    case (size)
      SZ_BYTE: be = 8'h01 << lane;
      SZ_HALF: be = 8'h03 << lane;
      SZ_WORD: be = 8'h0F << lane;
      default: be = 8'h00;
    endcase
    return be;
  endfunction

  // Copy the right-justified operand onto every lane of the bus.
  function automatic logic [MAX_DATA_W-1:0] lane_replicate(input logic [1:0] size,
                                                           input logic [MAX_DATA_W-1:0] data);
    logic [MAX_DATA_W-1:0] rep;
    case (size)
      SZ_BYTE: rep = {8{data[7:0]}};
      SZ_HALF: rep = {4{data[15:0]}};
      SZ_WORD: rep = {2{data[31:0]}};
      default: rep = '0;
    endcase
    return rep;
  endfunction

  // Pull the addressed sub-word out of bus read data and extend it.
  function automatic logic [MAX_DATA_W-1:0] read_extend(input logic [1:0] size,
                                                        input logic sgn,
                                                        input logic [2:0] lane,
                                                        input logic [MAX_DATA_W-1:0] rd);
    logic [MAX_DATA_W-1:0] sh;
    logic [MAX_DATA_W-1:0] res;
    sh = rd >> {lane, 3'b000};
    case (size)
      SZ_BYTE: res = {{56{sgn & sh[7]}}, sh[7:0]};
      SZ_HALF: res = {{48{sgn & sh[15]}}, sh[15:0]};
      SZ_WORD: res = {{32{sgn & sh[31]}}, sh[31:0]};
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mips_rr_arbiter.sv
// Request vector + search pointer -> one-hot grant and grant index.
module mips_rr_arbiter
  import mips_bus_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned RR_MODE = 1,
  localparam int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  idx,
  output logic              valid
);

  int unsigned cand;

  // First requester found scanning upward from ptr (RR) or from channel 0 (fixed).
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = (RR_MODE != 0) ? ((32'(ptr) + i) % NUM_CH) : i;
      if (!valid && req[IDX_W'(cand)]) begin
        valid = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

  assign grant = valid ? (NUM_CH'(1) << idx) : '0;

endmodule

// File: rtl/mips_bus_arbiter.sv
// Multi-channel Avalon-MM master: arbitration, lane encoding, read extraction, misalign rejection.
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RR_MODE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_we,
  input  logic [2*NUM_CH-1:0]      ch_size,
  input  logic [NUM_CH-1:0]        ch_signed,
  input  logic [ADDR_W*NUM_CH-1:0] ch_addr,
  input  logic [DATA_W*NUM_CH-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_ack,
  output logic [NUM_CH-1:0]        ch_err,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic                     busy,
  output logic [ADDR_W-1:0]        address,
  output logic                     read,
  output logic                     write,
  output logic [DATA_W-1:0]        writedata,
  output logic [DATA_W/8-1:0]      byteenable,
  input  logic                     waitrequest,
  input  logic [DATA_W-1:0]        readdata
);

  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned LANE_W = $clog2(BE_W);
  localparam int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  bus_state_t        state, state_d;
  logic [IDX_W-1:0]  rr_ptr, rr_ptr_d;
  logic [NUM_CH-1:0] arb_grant;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_valid;

  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [LANE_W-1:0] lane_q, lane_d;

  logic              sel_we;
  logic [1:0]        sel_size;
  logic              sel_sgn;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [LANE_W-1:0] sel_lane;
  logic              sel_err;

  logic              read_d, write_d, busy_d;
  logic [NUM_CH-1:0] ch_ack_d, ch_err_d;
  logic [DATA_W-1:0] ch_rdata_d;
  logic [ADDR_W-1:0] address_d;
  logic [DATA_W-1:0] writedata_d;
  logic [BE_W-1:0]   byteenable_d;

  mips_rr_arbiter #(
    .NUM_CH  (NUM_CH),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .req   (ch_req),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // Operand mux for the channel the arbiter currently picks.
  always_comb begin
    sel_we    = 1'b0;
    sel_size  = 2'b00;
    sel_sgn   = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        sel_we    = ch_we[i];
        sel_size  = ch_size[2*i +: 2];
        sel_sgn   = ch_signed[i];
        sel_addr  = ch_addr[ADDR_W*i +: ADDR_W];
        sel_wdata = ch_wdata[DATA_W*i +: DATA_W];
      end
    end
  end

  assign sel_lane = sel_addr[LANE_W-1:0];
  assign sel_err  = size_err(sel_size, sel_addr[1:0]);

  // Next state and next values for every registered output.
  always_comb begin
    state_d      = state;
    rr_ptr_d     = rr_ptr;
    grant_d      = grant_q;
    size_d       = size_q;
    sgn_d        = sgn_q;
    lane_d       = lane_q;
    read_d       = read;
    write_d      = write;
    address_d    = address;
    writedata_d  = writedata;
    byteenable_d = byteenable;
    ch_ack_d     = '0;
    ch_err_d     = '0;
    ch_rdata_d   = '0;
    unique case (state)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_d  = arb_grant;
          size_d   = sel_size;
          sgn_d    = sel_sgn;
          lane_d   = sel_lane;
          rr_ptr_d = (arb_idx == IDX_W'(NUM_CH - 1)) ? '0 : arb_idx + IDX_W'(1);
          if (sel_err) begin
            state_d  = ST_RESP;
            ch_ack_d = arb_grant;
            ch_err_d = arb_grant;
          end else begin
            state_d      = ST_BUS;
            read_d       = ~sel_we;
            write_d      = sel_we;
            address_d    = {sel_addr[ADDR_W-1:LANE_W], LANE_W'(0)};
            byteenable_d = BE_W'(be_mask(sel_size, 3'(sel_lane)));
            writedata_d  = DATA_W'(lane_replicate(sel_size, 64'(sel_wdata)));
          end
        end
      end
      ST_BUS: begin
        if (!waitrequest) begin
          state_d  = ST_RESP;
          ch_ack_d = grant_q;
          read_d   = 1'b0;
          write_d  = 1'b0;
          if (read) begin
            ch_rdata_d = DATA_W'(read_extend(size_q, sgn_q, 3'(lane_q), 64'(readdata)));
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Operand latches, RR pointer and registered bus/channel outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr     <= '0;
      grant_q    <= '0;
      size_q     <= 2'b00;
      sgn_q      <= 1'b0;
      lane_q     <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      busy       <= 1'b0;
      address    <= '0;
      writedata  <= '0;
      byteenable <= '0;
      ch_ack     <= '0;
      ch_err     <= '0;
      ch_rdata   <= '0;
    end else begin
      rr_ptr     <= rr_ptr_d;
      grant_q    <= grant_d;
      size_q     <= size_d;
      sgn_q      <= sgn_d;
      lane_q     <= lane_d;
      read       <= read_d;
      write      <= write_d;
      busy       <= busy_d;
      address    <= address_d;
      writedata  <= writedata_d;
      byteenable <= byteenable_d;
      ch_ack     <= ch_ack_d;
      ch_err     <= ch_err_d;
      ch_rdata   <= ch_rdata_d;
    end
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter: directed vector table, RR/fixed arbitration,
// mid-transaction reset, and randomized transactions against an arithmetic reference model.
module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ch_req, ch_we, ch_signed;
  logic [3:0]  ch_size;
  logic [63:0] ch_addr, ch_wdata;
  logic        waitrequest;
  logic [31:0] readdata;

  logic [1:0]  ch_ack, ch_err;
  logic [31:0] ch_rdata, address, writedata;
  logic        busy, read, write;
  logic [3:0]  byteenable;

  logic [1:0]  fp_ch_ack, fp_ch_err;
  logic [31:0] fp_ch_rdata, fp_address, fp_writedata;
  logic        fp_busy, fp_read, fp_write;
  logic [3:0]  fp_byteenable;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          ch;
    bit          we;
    logic [1:0]  size;
    bit          sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          waits;
    bit          err;
    logic [31:0] be;
    logic [31:0] wd;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [11];

  mips_bus_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .RR_MODE(1)) dut (
    .clk(clk), .reset(reset), .ch_req(ch_req), .ch_we(ch_we), .ch_size(ch_size),
    .ch_signed(ch_signed), .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_ack(ch_ack),
    .ch_err(ch_err), .ch_rdata(ch_rdata), .busy(busy), .address(address), .read(read),
    .write(write), .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata)
  );

  mips_bus_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .RR_MODE(0)) dut_fp (
    .clk(clk), .reset(reset), .ch_req(ch_req), .ch_we(ch_we), .ch_size(ch_size),
    .ch_signed(ch_signed), .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_ack(fp_ch_ack),
    .ch_err(fp_ch_err), .ch_rdata(fp_ch_rdata), .busy(fp_busy), .address(fp_address),
    .read(fp_read), .write(fp_write), .writedata(fp_writedata), .byteenable(fp_byteenable),
    .waitrequest(waitrequest), .readdata(readdata)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference behaviour from the access rules, using plain arithmetic.
  function automatic void model(input bit we, input logic [1:0] size, input bit sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rd, output bit err, output logic [31:0] be,
                                output logic [31:0] wd, output logic [31:0] rdata);
    longint unsigned lane, bits, mask, unit, acc, val;
    lane = 64'(addr % 4);
    err  = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
    bits = (size == 2'd0) ? 8 : (size == 2'd1) ? 16 : 32;
    mask = (64'd1 << bits) - 1;
    be   = 32'(((64'd1 << (bits / 8)) - 1) << lane);
    unit = 64'(wdata) & mask;
    acc  = 0;
    for (longint unsigned k = 0; k < 32; k += bits) acc |= unit << k;
    wd   = 32'(acc);
    val  = (64'(rd) >> (8 * lane)) & mask;
    if (sgn && ((val >> (bits - 1)) & 1) == 1) val |= ~mask;
    rdata = (err || we) ? 32'h0 : 32'(val);
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Issue one request on channel ch from an IDLE cycle and check the whole handshake.
  task automatic run_txn(input string tag, input vec_t v);
    int cyc, strobes, ack_cyc;
    bit bad, done;
    logic [1:0] ack_v, err_v;
    logic [31:0] rdata_v;
    logic busy_v;
    ch_req = 2'b00;
    ch_req[v.ch] = 1'b1;
    ch_we[v.ch] = v.we;
    ch_signed[v.ch] = v.sgn;
    ch_size[2*v.ch +: 2] = v.size;
    ch_addr[32*v.ch +: 32] = v.addr;
    ch_wdata[32*v.ch +: 32] = v.wdata;
    waitrequest = (v.waits > 0);
    readdata = v.rd;
    cyc = 0; strobes = 0; ack_cyc = -1; bad = 0; done = 0;
    ack_v = 2'b00; err_v = 2'b00; rdata_v = 32'h0; busy_v = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (read || write) begin
        strobes++;
        if (read !== !v.we || write !== v.we || address !== (v.addr & 32'hFFFF_FFFC) ||
            byteenable !== v.be[3:0] || (v.we && writedata !== v.wd) || busy !== 1'b1)
          bad = 1;
        waitrequest = (strobes <= v.waits);
      end
      if (ch_ack != 2'b00) begin
        done = 1; ack_cyc = cyc; ack_v = ch_ack; err_v = ch_err;
        rdata_v = ch_rdata; busy_v = busy;
        ch_req = 2'b00;
      end
    end
    ch_req = 2'b00;
    waitrequest = 1'b0;
    check({tag, " ack latency"}, 64'(ack_cyc), 64'(v.err ? 1 : 2 + v.waits));
    check({tag, " ch_ack"}, 64'(ack_v), 64'(2'b01 << v.ch));
    check({tag, " ch_err"}, 64'(err_v), v.err ? 64'(2'b01 << v.ch) : 64'h0);
    check({tag, " strobe cycles"}, 64'(strobes), 64'(v.err ? 0 : v.waits + 1));
    check({tag, " bus fields"}, 64'(bad), 64'h0);
    check({tag, " busy at ack"}, 64'(busy_v), 64'h1);
    if (!v.we || v.err) check({tag, " ch_rdata"}, 64'(rdata_v), 64'(v.rdata));
    @(negedge clk);
  endtask

  initial begin
    vec_t rv;
    logic [1:0] got [4];
    logic [1:0] gotf [4];
    int n, nf, cyc;
    bit seen;

    reset = 1'b0; ch_req = '0; ch_we = '0; ch_signed = '0; ch_size = '0;
    ch_addr = '0; ch_wdata = '0; waitrequest = 1'b0; readdata = '0;

    //            ch we size  sgn addr          wdata         rd            wt err be     wd            rdata
    vecs[0]  = '{0, 0, 2'd2, 0, 32'h0000_1000, 32'h0,        32'hDEAD_BEEF, 0, 0, 32'hF, 32'h0,        32'hDEAD_BEEF};
    vecs[1]  = '{0, 0, 2'd0, 1, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 0, 32'h8, 32'h0,        32'hFFFF_FF80};
    vecs[2]  = '{1, 0, 2'd0, 0, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 0, 32'h8, 32'h0,        32'h0000_0080};
    vecs[3]  = '{1, 1, 2'd1, 0, 32'h0000_2002, 32'h0000_ABCD, 32'h0,        3, 0, 32'hC, 32'hABCD_ABCD, 32'h0};
    vecs[4]  = '{0, 0, 2'd2, 0, 32'h0000_1002, 32'h0,        32'h1234_5678, 0, 1, 32'h0, 32'h0,        32'h0};
    vecs[5]  = '{1, 1, 2'd0, 0, 32'h0000_3001, 32'h1234_5677, 32'h0,        0, 0, 32'h2, 32'h7777_7777, 32'h0};
    vecs[6]  = '{0, 0, 2'd1, 1, 32'h0000_4002, 32'h0,        32'h8001_7FFF, 1, 0, 32'hC, 32'h0,        32'hFFFF_8001};
    vecs[7]  = '{0, 0, 2'd1, 1, 32'h0000_4000, 32'h0,        32'h8001_7FFF, 0, 0, 32'h3, 32'h0,        32'h0000_7FFF};
    vecs[8]  = '{1, 0, 2'd1, 0, 32'h0000_4001, 32'h0,        32'hFFFF_FFFF, 0, 1, 32'h0, 32'h0,        32'h0};
    vecs[9]  = '{0, 1, 2'd3, 0, 32'h0000_5000, 32'h1111_2222, 32'h0,        0, 1, 32'h0, 32'h0,        32'h0};
    vecs[10] = '{0, 1, 2'd2, 0, 32'h0000_6004, 32'hCAFE_F00D, 32'h0,        1, 0, 32'hF, 32'hCAFE_F00D, 32'h0};

    // Reset values while reset is held low.
    @(negedge clk);
    check("reset read", 64'(read), 64'h0);
    check("reset write", 64'(write), 64'h0);
    check("reset busy", 64'(busy), 64'h0);
    check("reset ch_ack", 64'(ch_ack), 64'h0);
    check("reset ch_err", 64'(ch_err), 64'h0);
    check("reset address", 64'(address), 64'h0);
    check("reset writedata", 64'(writedata), 64'h0);
    check("reset byteenable", 64'(byteenable), 64'h0);
    check("reset ch_rdata", 64'(ch_rdata), 64'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Directed vector table.
    for (int i = 0; i < 11; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

    // Both channels requesting continuously: RR alternates, fixed priority starves ch1.
    do_reset();
    ch_we = 2'b00; ch_size = 4'b1010; ch_signed = 2'b00;
    ch_addr = {32'h0000_0004, 32'h0000_0000};
    waitrequest = 1'b0; readdata = 32'h1111_2222;
    for (int i = 0; i < 4; i++) begin got[i] = 2'b00; gotf[i] = 2'b00; end
    n = 0; nf = 0; cyc = 0;
    ch_req = 2'b11;
    while (n < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (ch_ack != 2'b00) begin got[n] = ch_ack; n++; end
      if (fp_ch_ack != 2'b00 && nf < 4) begin gotf[nf] = fp_ch_ack; nf++; end
      if (n == 4) ch_req = 2'b00;
    end
    ch_req = 2'b00;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr grant %0d", i), 64'(got[i]), (i % 2 == 0) ? 64'h1 : 64'h2);
      check($sformatf("fixed grant %0d", i), 64'(gotf[i]), 64'h1);
    end
    @(negedge clk);

    // Randomized transactions against the reference model.
    for (int i = 0; i < 40; i++) begin
      rv.ch    = int'($urandom_range(0, 1));
      rv.we    = 1'($urandom_range(0, 1));
      rv.size  = 2'($urandom_range(0, 3));
      rv.sgn   = 1'($urandom_range(0, 1));
      rv.addr  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (rv.size == 2'd1) rv.addr[0] = 1'b0;
        if (rv.size == 2'd2) rv.addr[1:0] = 2'b00;
      end
      rv.wdata = $urandom;
      rv.rd    = $urandom;
      rv.waits = int'($urandom_range(0, 3));
      model(rv.we, rv.size, rv.sgn, rv.addr, rv.wdata, rv.rd, rv.err, rv.be, rv.wd, rv.rdata);
      run_txn($sformatf("rnd%0d", i), rv);
    end

    // Reset in the middle of a stalled read: strobe drops at once, no ack follows.
    ch_req = 2'b01; ch_we = 2'b00; ch_size = 4'b0010; ch_addr = 64'h0000_0100;
    waitrequest = 1'b1;
    seen = 0; cyc = 0;
    while (!seen && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (read) seen = 1;
    end
    check("midreset read seen", 64'(seen), 64'h1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midreset read", 64'(read), 64'h0);
    check("midreset write", 64'(write), 64'h0);
    check("midreset busy", 64'(busy), 64'h0);
    ch_req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    waitrequest = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (ch_ack != 2'b00 || read || write) seen = 1;
    end
    check("midreset no ack", 64'(seen), 64'h0);
    rv = '{1, 0, 2'd2, 0, 32'h0000_0200, 32'h0, 32'h0BAD_F00D, 0, 0, 32'hF, 32'h0, 32'h0BAD_F00D};
    run_txn("post-reset ch1", rv);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
